// File: rtl/sort_job_sequencer_if.sv
// Input/output word streams of the sort job sequencer.
// The master side produces input words and consumes sorted output words.
interface sort_job_sequencer_if #(
  parameter int unsigned N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/sort_job_sequencer.sv
// Job-level controller for sorting_top: loads 2**L words, starts the sort with a timeout,
// then drains the sorted words as an output stream.
module sort_job_sequencer #(
  parameter int unsigned N       = 16,
  parameter int unsigned L       = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  sort_job_sequencer_if.slave   stream,
  input  logic                  clr_err,
  output logic                  busy,
  output logic                  err_timeout,
  output logic [7:0]            job_cnt,
  output logic                  s_wrinit,
  output logic                  s_rd,
  output logic [L-1:0]          s_raddr,
  output logic [N-1:0]          s_datain,
  output logic                  s_start,
  input  logic [N-1:0]          s_dataout,
  input  logic                  s_done
);

  localparam int unsigned DEPTH = 1 << L;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_SORT, S_READ, S_CAP, S_SEND, S_ERR
  } state_t;

  state_t         r_state,     w_state;
  logic [L-1:0]   r_wptr,      w_wptr;
  logic [L-1:0]   r_rptr,      w_rptr;
  logic [TMO_W-1:0] r_tmo,     w_tmo;
  logic           r_out_valid, w_out_valid;
  logic [N-1:0]   r_out_data,  w_out_data;
  logic           r_out_last,  w_out_last;
  logic           r_err,       w_err;
  logic [7:0]     r_job_cnt,   w_job_cnt;
  logic           r_busy;
  logic           w_in_ready;
  logic           w_wrinit;
  logic           w_rd;
  logic           w_start;
  logic [L-1:0]   w_raddr;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_tmo       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
      r_job_cnt   <= 8'd0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_wptr      <= w_wptr;
      r_rptr      <= w_rptr;
      r_tmo       <= w_tmo;
      r_out_valid <= w_out_valid;
      r_out_data  <= w_out_data;
      r_out_last  <= w_out_last;
      r_err       <= w_err;
      r_job_cnt   <= w_job_cnt;
      r_busy      <= (w_state != S_IDLE) && (w_state != S_ERR);
    end
  end

  // Next-state, datapath updates and sorter strobes
  always_comb begin
    w_state     = r_state;
    w_wptr      = r_wptr;
    w_rptr      = r_rptr;
    w_tmo       = r_tmo;
    w_out_valid = r_out_valid;
    w_out_data  = r_out_data;
    w_out_last  = r_out_last;
    w_err       = r_err;
    w_job_cnt   = r_job_cnt;
    w_in_ready  = 1'b0;
    w_wrinit    = 1'b0;
    w_rd        = 1'b0;
    w_start     = 1'b0;
    w_raddr     = '0;

    unique case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (stream.in_valid) begin
          w_wrinit = 1'b1;
          w_wptr   = L'(1);
          w_state  = S_LOAD;
        end
      end
      S_LOAD: begin
        w_in_ready = 1'b1;
        if (stream.in_valid) begin
          w_wrinit = 1'b1;
          w_raddr  = r_wptr;
          w_wptr   = r_wptr + L'(1);
          if (r_wptr == L'(DEPTH - 1)) w_state = S_START;
        end
      end
      S_START: begin
        w_start = 1'b1;
        w_tmo   = '0;
        w_state = S_SORT;
      end
      S_SORT: begin
        // tmo==0 marks the first SORT cycle, where a stale done is ignored
        w_tmo = r_tmo + TMO_W'(1);
        if ((r_tmo != '0) && s_done) begin
          w_rptr  = '0;
          w_state = S_READ;
        end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
          w_err   = 1'b1;
          w_state = S_ERR;
        end
      end
      S_READ: begin
        w_rd    = 1'b1;
        w_raddr = r_rptr;
        w_state = S_CAP;
      end
      S_CAP: begin
        w_out_data  = s_dataout;
        w_out_valid = 1'b1;
        w_out_last  = (r_rptr == L'(DEPTH - 1));
        w_state     = S_SEND;
      end
      S_SEND: begin
        if (stream.out_ready) begin
          w_out_valid = 1'b0;
          if (r_out_last) begin
            w_job_cnt = r_job_cnt + 8'd1;
            w_state   = S_IDLE;
          end else begin
            w_rptr  = r_rptr + L'(1);
            w_state = S_READ;
          end
        end
      end
      S_ERR: begin
        if (clr_err) begin
          w_err   = 1'b0;
          w_state = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase

    // Nothing is accepted or written while reset is held
    if (!rst) begin
      w_in_ready = 1'b0;
      w_wrinit   = 1'b0;
      w_raddr    = '0;
    end
  end

  assign stream.in_ready  = w_in_ready;
  assign stream.out_valid = r_out_valid;
  assign stream.out_data  = r_out_data;
  assign stream.out_last  = r_out_last;
  assign busy             = r_busy;
  assign err_timeout      = r_err;
  assign job_cnt          = r_job_cnt;
  assign s_wrinit         = w_wrinit;
  assign s_rd             = w_rd;
  assign s_raddr          = w_raddr;
  assign s_datain         = stream.in_data;
  assign s_start          = w_start;

endmodule

// File: tb/tb_sort_job_sequencer.sv
// Directed bench for sort_job_sequencer with a behavioural sorter model.
module tb_sort_job_sequencer;

  localparam int unsigned N     = 16;
  localparam int unsigned L     = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned TMO   = 64;

  logic         clk;
  logic         rst;
  logic         clr_err;
  logic         busy;
  logic         err_timeout;
  logic [7:0]   job_cnt;
  logic         s_wrinit;
  logic         s_rd;
  logic [L-1:0] s_raddr;
  logic [N-1:0] s_datain;
  logic         s_start;
  logic [N-1:0] s_dataout;
  logic         s_done;

  sort_job_sequencer_if #(.N(N)) sif ();

  sort_job_sequencer #(.N(N), .L(L), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .stream      (sif),
    .clr_err     (clr_err),
    .busy        (busy),
    .err_timeout (err_timeout),
    .job_cnt     (job_cnt),
    .s_wrinit    (s_wrinit),
    .s_rd        (s_rd),
    .s_raddr     (s_raddr),
    .s_datain    (s_datain),
    .s_start     (s_start),
    .s_dataout   (s_dataout),
    .s_done      (s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Sorter model: sorts its memory and raises done done_delay cycles after start
  logic [N-1:0] mem [DEPTH];
  int  m_cnt;
  bit  m_run;
  int  done_delay;
  bit  stale_mode;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_done    <= 1'b0;
      s_dataout <= '0;
      m_run      = 1'b0;
      m_cnt      = 0;
    end else begin
      if (s_wrinit) mem[s_raddr] = s_datain;
      if (s_rd) s_dataout <= mem[s_raddr];
      if (s_start) begin
        m_run = 1'b1;
        m_cnt = 0;
        if (!stale_mode) s_done <= 1'b0;
      end else if (m_run) begin
        m_cnt++;
        if (done_delay != 0 && m_cnt == done_delay) begin
          for (int i = 0; i < DEPTH - 1; i++)
            for (int j = 0; j < DEPTH - 1 - i; j++)
              if (mem[j] > mem[j+1]) begin
                logic [N-1:0] t;
                t        = mem[j];
                mem[j]   = mem[j+1];
                mem[j+1] = t;
              end
          s_done <= 1'b1;
          m_run   = 1'b0;
        end else begin
          s_done <= 1'b0;
        end
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor, sampled on the falling edge
  int n_wr, n_start, n_viol, addr_bad, wr_exp, stall_bad;
  int t_start, t_rd, t_err;
  bit rd_seen, err_seen, have_prev;
  logic [N-1:0] prev_d;
  logic         prev_l;
  logic [N-1:0] od [$];
  bit           ol [$];

  always @(negedge clk) begin
    if (rst) begin
      if (s_wrinit) begin
        if (32'(s_raddr) != (wr_exp % DEPTH)) addr_bad++;
        wr_exp++;
        n_wr++;
      end
      if (s_wrinit && s_rd) n_viol++;
      if (!s_wrinit && !s_rd && s_raddr != '0) n_viol++;
      if (s_start) begin
        n_start++;
        t_start = cyc;
        rd_seen = 1'b0;
      end
      if (s_rd && !rd_seen) begin
        rd_seen = 1'b1;
        t_rd    = cyc;
      end
      if (err_timeout && !err_seen) begin
        err_seen = 1'b1;
        t_err    = cyc;
      end
      if (sif.out_valid) begin
        if (have_prev && (sif.out_data != prev_d || sif.out_last != prev_l)) stall_bad++;
        if (sif.out_ready) begin
          od.push_back(sif.out_data);
          ol.push_back(sif.out_last);
          have_prev = 1'b0;
        end else begin
          have_prev = 1'b1;
          prev_d    = sif.out_data;
          prev_l    = sif.out_last;
        end
      end else begin
        have_prev = 1'b0;
      end
    end
  end

  int ready_mode;
  initial begin
    sif.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       sif.out_ready = 1'b1;
        1:       sif.out_ready = ~sif.out_ready;
        default: sif.out_ready = 1'b0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    n_wr = 0; n_start = 0; n_viol = 0; addr_bad = 0; wr_exp = 0; stall_bad = 0;
    t_start = 0; t_rd = 0; t_err = 0;
    rd_seen = 1'b0; err_seen = 1'b0; have_prev = 1'b0;
    od.delete();
    ol.delete();
  endtask

  task automatic send_word(input logic [N-1:0] d, input int gap);
    bit rdy;
    int k;
    sif.in_valid = 1'b1;
    sif.in_data  = d;
    k = 0;
    forever begin
      rdy = sif.in_ready;
      tick();
      k++;
      if (rdy) break;
      if (k > 200) begin
        check_val("in_accept_timeout", 32'(k), 32'd0);
        break;
      end
    end
    sif.in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic load_job(input logic [N-1:0] w [DEPTH], input int gap);
    for (int i = 0; i < DEPTH; i++) send_word(w[i], gap);
  endtask

  task automatic wait_outputs();
    int k;
    k = 0;
    while (od.size() < DEPTH && k < 3000) begin
      tick();
      k++;
    end
    check_val("job_complete", 32'(od.size()), 32'(DEPTH));
    repeat (2) tick();
  endtask

  task automatic check_out(input string tag, input logic [N-1:0] e [DEPTH]);
    int nlast;
    nlast = 0;
    for (int i = 0; i < DEPTH; i++) begin
      check_val(tag, 32'(od[i]), 32'(e[i]));
      if (ol[i]) nlast++;
    end
    check_val({tag, "_last_cnt"}, 32'(nlast), 32'd1);
    check_val({tag, "_last_pos"}, 32'(ol[DEPTH-1]), 32'd1);
  endtask

  logic [N-1:0] desc [DEPTH];
  logic [N-1:0] perm [DEPTH];
  logic [N-1:0] wide [DEPTH];
  logic [N-1:0] asc  [DEPTH];
  logic [N-1:0] wasc [DEPTH];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      desc[i] = N'(15 - i);
      perm[i] = N'((i * 5) % 16);
      wide[i] = N'(16'hF000 - i * 16'h0100);
      asc[i]  = N'(i);
      wasc[i] = N'(16'hE100 + i * 16'h0100);
    end
    rst = 1'b0; clr_err = 1'b0;
    sif.in_valid = 1'b0; sif.in_data = '0;
    ready_mode = 0; stale_mode = 1'b0; done_delay = 20;
    clr_mon();
    repeat (3) tick();

    // Reset values
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_in_ready", 32'(sif.in_ready), 32'd0);
    check_val("rst_out_valid", 32'(sif.out_valid), 32'd0);
    check_val("rst_out_data", 32'(sif.out_data), 32'd0);
    check_val("rst_err", 32'(err_timeout), 32'd0);
    check_val("rst_job_cnt", 32'(job_cnt), 32'd0);
    check_val("rst_strobes", {29'd0, s_wrinit, s_rd, s_start}, 32'd0);
    rst = 1'b1;
    tick();
    check_val("idle_in_ready", 32'(sif.in_ready), 32'd1);

    // 1: descending load, free-running output
    clr_mon();
    load_job(desc, 0);
    wait_outputs();
    check_out("t1_data", asc);
    check_val("t1_job_cnt", 32'(job_cnt), 32'd1);
    check_val("t1_starts", 32'(n_start), 32'd1);
    check_val("t1_latency", 32'(t_rd - t_start), 32'd22);
    check_val("t1_writes", 32'(n_wr), 32'd16);
    check_val("t1_busy", 32'(busy), 32'd0);

    // 2: output back-pressure
    ready_mode = 1;
    clr_mon();
    load_job(desc, 0);
    wait_outputs();
    check_out("t2_data", asc);
    check_val("t2_stall_stable", 32'(stall_bad), 32'd0);
    check_val("t2_job_cnt", 32'(job_cnt), 32'd2);
    ready_mode = 0;

    // 3: sparse input
    clr_mon();
    load_job(perm, 2);
    wait_outputs();
    check_out("t3_data", asc);
    check_val("t3_writes", 32'(n_wr), 32'd16);
    check_val("t3_addr_seq", 32'(addr_bad), 32'd0);
    check_val("t3_starts", 32'(n_start), 32'd1);
    check_val("t3_job_cnt", 32'(job_cnt), 32'd3);

    // 5: done still high from the previous job at start
    check_val("t5_done_pre", 32'(s_done), 32'd1);
    stale_mode = 1'b1;
    clr_mon();
    load_job(desc, 0);
    wait_outputs();
    check_out("t5_data", asc);
    check_val("t5_latency", 32'(t_rd - t_start), 32'd22);
    check_val("t5_job_cnt", 32'(job_cnt), 32'd4);
    stale_mode = 1'b0;

    // 4: sorter never finishes
    done_delay = 0;
    clr_mon();
    load_job(desc, 0);
    begin
      int k;
      k = 0;
      while (!err_seen && k < 300) begin
        tick();
        k++;
      end
    end
    check_val("t4_err_seen", 32'(err_seen), 32'd1);
    check_val("t4_err_time", 32'(t_err - t_start), 32'd65);
    check_val("t4_busy", 32'(busy), 32'd0);
    check_val("t4_in_ready", 32'(sif.in_ready), 32'd0);
    check_val("t4_no_read", 32'(rd_seen), 32'd0);
    repeat (3) tick();
    check_val("t4_err_sticky", 32'(err_timeout), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check_val("t4_err_clr", 32'(err_timeout), 32'd0);
    check_val("t4_idle_ready", 32'(sif.in_ready), 32'd1);
    check_val("t4_job_cnt", 32'(job_cnt), 32'd4);
    done_delay = 20;

    // 6: reset during SORT, then during SEND
    clr_mon();
    load_job(desc, 0);
    repeat (3) tick();
    check_val("t6_in_sort", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check_val("t6a_busy", 32'(busy), 32'd0);
    check_val("t6a_job_cnt", 32'(job_cnt), 32'd0);
    check_val("t6a_in_ready", 32'(sif.in_ready), 32'd0);
    check_val("t6a_strobes", {29'd0, s_wrinit, s_rd, s_start}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    ready_mode = 2;
    clr_mon();
    load_job(desc, 0);
    begin
      int k;
      k = 0;
      while (!sif.out_valid && k < 200) begin
        tick();
        k++;
      end
    end
    check_val("t6_in_send", 32'(sif.out_valid), 32'd1);
    rst = 1'b0;
    #1;
    check_val("t6b_out_valid", 32'(sif.out_valid), 32'd0);
    check_val("t6b_out_data", 32'(sif.out_data), 32'd0);
    check_val("t6b_out_last", 32'(sif.out_last), 32'd0);
    check_val("t6b_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b1;
    ready_mode = 0;
    tick();
    clr_mon();
    load_job(wide, 0);
    wait_outputs();
    check_out("t6_data", wasc);
    check_val("t6_job_cnt", 32'(job_cnt), 32'd1);

    check_val("strobe_rules", 32'(n_viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
